ssd_scan_decoder: RTL and testbench
===================================

Name: ssd_scan_decoder

Overview:
- Receive-side counterpart of the hex-to-seven-segment encoder used on the Basys3 anode display.
- Monitors the multiplexed anode/segment bus (active-low) and reconstructs the four displayed hex nibbles.
- Flags illegal segment patterns and signals each completed scan frame.
- Used as a self-check monitor beside the display driver, and as a loopback receiver when the bus is routed off-board.

Parameters:
- STABLE_CYCLES, 4: consecutive synchronized cycles an (an, seg) pair must hold before it is captured. Legal range 2..255.
- CNT_W, 8: width of the stability counter. Must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- an  input  4  anode enables, active-low; an[i]=0 selects digit i
- seg  input  7  segments {a,b,c,d,e,f,g}, active-low, a = seg[6]
- digits  output  16  decoded nibbles; digit i is digits[4i+3:4i]
- digit_valid  output  4  digit_valid[i]=1 when digits nibble i holds a legally decoded value
- frame_done  output  1  one-cycle pulse when all four digits have been captured since the last pulse
- pattern_err  output  1  one-cycle pulse on capture of an unrecognised, non-blank pattern
- err_digit  output  2  index of the digit that caused the last pattern_err; holds until the next error

Behaviour:
- Reset: async on rst_n low. digits=16'h0000, digit_valid=4'b0000, frame_done=0, pattern_err=0, err_digit=2'd0, synchronizers=all-ones, counter=0, seen mask=0, state=IDLE.
- Input sync: an and seg each pass through two flops. All further logic uses the second stage.
- Stability counter:
  - Clears to 1 when the synchronized {an,seg} differs from the previous cycle's value.
  - Otherwise increments, saturating at STABLE_CYCLES.
  - A capture fires in the single cycle the counter reaches STABLE_CYCLES. A held value captures only once.
- State machine:
  - IDLE: the synchronized an is not one-hot-low (4'b1111, or two or more zeros). No capture. Go to SETTLE when an becomes one-hot-low.
  - SETTLE: counting. Any change of an or seg restarts the count. Go to IDLE if an becomes illegal. On reaching STABLE_CYCLES, perform the capture and go to HOLD.
  - HOLD: wait. Any change of the pair goes to SETTLE (or IDLE if an is illegal).
- Capture, where i is the index of the low anode:
  - Legal pattern: decode seg to a nibble using exactly the inverse of the display encoder: 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9, 0001000→A, 1100000→B, 0110001→C, 1000010→D, 0010000→E, 0111000→F. Write nibble i, set digit_valid[i]=1, set seen[i]=1.
  - Blank (7'b1111111): clear digit_valid[i], keep nibble i unchanged, set seen[i]=1, no error.
  - Any other pattern: clear digit_valid[i], keep nibble i unchanged, pulse pattern_err, load err_digit=i, leave seen[i] unchanged.
- Outputs are registered and update the cycle after the capture decision.
  - End-to-end latency from a pin change to the output update is STABLE_CYCLES+2 clocks.
- Frame:
  - When a capture makes seen==4'b1111, pulse frame_done in the same cycle the outputs update, and clear seen to 0.
  - Re-capturing an already-seen digit is allowed and does not advance the frame.
- Simultaneous events: at most one capture per cycle, so the frame and error pulses never come from different digits in the same cycle. A pattern_err capture never asserts frame_done.
- Reset mid-operation: all state is cleared immediately. After release, the first capture requires a full STABLE_CYCLES settle on synchronized data.
- Glitches shorter than STABLE_CYCLES synchronized cycles are never captured.

Test Plan:
- Reset check: hold rst_n=0 with an=4'b1110, seg=7'b1001111 → digits=0, digit_valid=0, no pulses. Release reset → digit 0 = 1 and digit_valid=4'b0001 exactly STABLE_CYCLES+2 clocks later.
- Full frame: scan an=1110,1101,1011,0111 with seg for 3,A,C,F, each held 10 cycles → digits=16'hFCA3, digit_valid=4'b1111, a single frame_done pulse on the fourth capture.
- Glitch rejection: within a held digit, toggle seg to 7'b0000000 for STABLE_CYCLES-1 cycles, then restore → digits unchanged, no extra capture, no error.
- Illegal pattern: an=4'b1011, seg=7'b1111110 held → pattern_err pulses once, err_digit=2, digit_valid[2]=0, nibble 2 retains its prior value, no frame_done.
- Blank and illegal anode:
  - seg=7'b1111111 on digit 1 → digit_valid[1]=0, no error.
  - an=4'b1100 held 20 cycles → no capture and no output change.
- Mid-settle reset: assert rst_n low two cycles into SETTLE → all outputs return to reset values. After release, no capture occurs before STABLE_CYCLES+2 clocks.

Source files
------------

// File: rtl/ssd_scan_decoder.sv
// Receive-side monitor for a multiplexed, active-low seven-segment bus.
// Reconstructs the four displayed hex nibbles, flags illegal patterns, marks frames.
module ssd_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        frame_done,
  output logic        pattern_err,
  output logic [1:0]  err_digit
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;
  typedef enum logic [1:0] {PAT_LEGAL, PAT_BLANK, PAT_ILLEGAL} pat_t;

  localparam logic [CNT_W-1:0] LP_STABLE = CNT_W'(STABLE_CYCLES);

  logic [3:0]       r_an_s1, r_an_s2;
  logic [6:0]       r_seg_s1, r_seg_s2;
  logic [10:0]      r_prev;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;
  logic [3:0]       r_seen;
  logic [15:0]      r_digits;
  logic [3:0]       r_valid;
  logic             r_frame_done;
  logic             r_pattern_err;
  logic [1:0]       r_err_digit;

  logic [10:0]      w_pair;
  logic             w_changed;
  logic [CNT_W-1:0] w_cnt;
  logic             w_reach;
  logic             w_onehot;
  logic [1:0]       w_idx;
  state_t           w_state_nx;
  logic             w_capture;
  logic [3:0]       w_nib;
  pat_t             w_pat;
  logic [3:0]       w_seen_nx;
  logic [15:0]      w_digits_nx;
  logic [3:0]       w_valid_nx;
  logic             w_fd_nx;
  logic             w_pe_nx;
  logic [1:0]       w_err_nx;

  // NOTE: the synchronizers and the previous-pair register reset to all-ones (no
  // anode selected), so the first real bus value after reset always restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an_s1  <= '1;
      r_an_s2  <= '1;
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
      r_prev   <= '1;
      r_cnt    <= '0;
      r_state  <= S_IDLE;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // which is what gives the two-stage synchronizer its two cycles of delay.
      r_an_s1  <= an;
      r_an_s2  <= r_an_s1;
      r_seg_s1 <= seg;
      r_seg_s2 <= r_seg_s1;
      r_prev   <= w_pair;
      r_cnt    <= w_cnt;
      r_state  <= w_state_nx;
    end
  end

  assign w_pair    = {r_an_s2, r_seg_s2};
  assign w_changed = (w_pair != r_prev);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_cnt = r_cnt;
    if (w_changed)
      w_cnt = CNT_W'(1);
    else if (r_cnt < LP_STABLE)
      w_cnt = r_cnt + 1'b1;
  end

  // True only in the one cycle the count arrives at the threshold.
  assign w_reach = (w_cnt == LP_STABLE) && (r_cnt != LP_STABLE);

  always_comb begin
    w_onehot = 1'b0;
    w_idx    = 2'd0;
    case (r_an_s2)
      4'b1110: begin w_onehot = 1'b1; w_idx = 2'd0; end
      4'b1101: begin w_onehot = 1'b1; w_idx = 2'd1; end
      4'b1011: begin w_onehot = 1'b1; w_idx = 2'd2; end
      4'b0111: begin w_onehot = 1'b1; w_idx = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_capture  = 1'b0;
    if (!w_onehot) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_state_nx = S_SETTLE;
        S_SETTLE: if (w_reach) begin
                    w_capture  = 1'b1;
                    w_state_nx = S_HOLD;
                  end
        S_HOLD:   if (w_changed) w_state_nx = S_SETTLE;
        default:  w_state_nx = S_IDLE;
      endcase
    end
  end

  // Exact inverse of the display encoder's hex table.
  always_comb begin
    w_nib = 4'h0;
    w_pat = PAT_LEGAL;
    case (r_seg_s2)
      7'b0000001: w_nib = 4'h0;
      7'b1001111: w_nib = 4'h1;
      7'b0010010: w_nib = 4'h2;
      7'b0000110: w_nib = 4'h3;
      7'b1001100: w_nib = 4'h4;
      7'b0100100: w_nib = 4'h5;
      7'b0100000: w_nib = 4'h6;
      7'b0001111: w_nib = 4'h7;
      7'b0000000: w_nib = 4'h8;
      7'b0000100: w_nib = 4'h9;
      7'b0001000: w_nib = 4'hA;
      7'b1100000: w_nib = 4'hB;
      7'b0110001: w_nib = 4'hC;
      7'b1000010: w_nib = 4'hD;
      7'b0010000: w_nib = 4'hE;
      7'b0111000: w_nib = 4'hF;
      7'b1111111: w_pat = PAT_BLANK;
      default:    w_pat = PAT_ILLEGAL;
    endcase
  end

  always_comb begin
    w_seen_nx   = r_seen;
    w_digits_nx = r_digits;
    w_valid_nx  = r_valid;
    w_err_nx    = r_err_digit;
    w_fd_nx     = 1'b0;
    w_pe_nx     = 1'b0;
    if (w_capture) begin
      case (w_pat)
        PAT_LEGAL: begin
          w_digits_nx[{w_idx, 2'b00} +: 4] = w_nib;
          w_valid_nx[w_idx] = 1'b1;
          w_seen_nx[w_idx]  = 1'b1;
        end
        PAT_BLANK: begin
          w_valid_nx[w_idx] = 1'b0;
          w_seen_nx[w_idx]  = 1'b1;
        end
        default: begin
          w_valid_nx[w_idx] = 1'b0;
          w_pe_nx           = 1'b1;
          w_err_nx          = w_idx;
        end
      endcase
    end
    if (w_seen_nx == 4'b1111) begin
      w_fd_nx   = 1'b1;
      w_seen_nx = 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen        <= '0;
      r_digits      <= '0;
      r_valid       <= '0;
      r_frame_done  <= 1'b0;
      r_pattern_err <= 1'b0;
      r_err_digit   <= 2'd0;
    end else begin
      r_seen        <= w_seen_nx;
      r_digits      <= w_digits_nx;
      r_valid       <= w_valid_nx;
      r_frame_done  <= w_fd_nx;
      r_pattern_err <= w_pe_nx;
      r_err_digit   <= w_err_nx;
    end
  end

  assign digits      = r_digits;
  assign digit_valid = r_valid;
  assign frame_done  = r_frame_done;
  assign pattern_err = r_pattern_err;
  assign err_digit   = r_err_digit;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Bench for ssd_scan_decoder: directed scenarios plus random bus traffic, all checked
// cycle by cycle against a history-window reference model of the display bus.
module tb_ssd_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        pattern_err;
  logic [1:0]  err_digit;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [6:0]  enc_tab [16];
  logic [10:0] hist [$];
  logic [15:0] m_digits;
  logic [3:0]  m_valid;
  logic [3:0]  m_seen;
  logic        m_fd;
  logic        m_pe;
  logic [1:0]  m_err;

  int    cyc_err;
  int    fd_cnt;
  int    pe_cnt;
  string mm_note;

  ssd_scan_decoder #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .seg         (seg),
    .digits      (digits),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .pattern_err (pattern_err),
    .err_digit   (err_digit)
  );

  always #5 clk = ~clk;

  // History holds the pin value seen at each clock edge; all-ones stands for "in reset".
  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < S + 3; k++) hist.push_back(11'h7FF);
    m_digits = '0;
    m_valid  = '0;
    m_seen   = '0;
    m_fd     = 1'b0;
    m_pe     = 1'b0;
    m_err    = 2'd0;
  endtask

  // An (an,seg) value is captured when it has been on the pins for exactly S edges,
  // ending two edges ago (two sync flops), and it selects exactly one digit.
  task automatic model_step(input logic [10:0] p);
    logic [10:0] v;
    logic [3:0]  sel;
    bit          run_ok;
    int          n;
    int          idx;
    int          nib;
    m_fd = 1'b0;
    m_pe = 1'b0;
    hist.push_back(p);
    void'(hist.pop_front());
    n = hist.size();
    v = hist[n-3];
    run_ok = 1'b1;
    for (int k = n - 2 - S; k <= n - 3; k++) if (hist[k] != v) run_ok = 1'b0;
    if (hist[n-3-S] == v) run_ok = 1'b0;
    idx = -1;
    for (int k = 0; k < 4; k++) begin
      sel = 4'b1111;
      sel[k] = 1'b0;
      if (v[10:7] == sel) idx = k;
    end
    if (run_ok && idx >= 0) begin
      nib = -1;
      for (int k = 0; k < 16; k++) if (enc_tab[k] == v[6:0]) nib = k;
      if (nib >= 0) begin
        m_digits[idx*4 +: 4] = 4'(nib);
        m_valid[idx] = 1'b1;
        m_seen[idx]  = 1'b1;
      end else if (v[6:0] == 7'h7F) begin
        m_valid[idx] = 1'b0;
        m_seen[idx]  = 1'b1;
      end else begin
        m_valid[idx] = 1'b0;
        m_pe         = 1'b1;
        m_err        = 2'(idx);
      end
      if (m_seen == 4'hF) begin
        m_fd   = 1'b1;
        m_seen = 4'h0;
      end
    end
  endtask

  // One clock: drive pins, advance the model at the edge, sample the DUT 1 time unit later.
  task automatic tick(input logic [3:0] a, input logic [6:0] s);
    an  = a;
    seg = s;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step({a, s});
    #1;
    if (frame_done)  fd_cnt++;
    if (pattern_err) pe_cnt++;
    if ({digits, digit_valid, frame_done, pattern_err, err_digit} !==
        {m_digits, m_valid, m_fd, m_pe, m_err}) begin
      if (cyc_err == 0)
        mm_note = $sformatf("t=%0t digits=%h/%h valid=%b/%b fd=%b/%b pe=%b/%b err=%0d/%0d",
                            $time, digits, m_digits, digit_valid, m_valid, frame_done, m_fd,
                            pattern_err, m_pe, err_digit, m_err);
      cyc_err++;
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    for (int k = 0; k < n; k++) tick(a, s);
  endtask

  task automatic start_scenario();
    cyc_err = 0;
    fd_cnt  = 0;
    pe_cnt  = 0;
    mm_note = "";
  endtask

  task automatic test_reset();
    int n;
    start_scenario();
    rst_n = 1'b0;
    hold(4'b1110, 7'b1001111, 3);
    checks++;
    if (digits !== 16'h0000) begin failures++; $display("FAIL reset_digits: got %h want 0000", digits); end
    checks++;
    if (digit_valid !== 4'b0000) begin failures++; $display("FAIL reset_valid: got %b want 0000", digit_valid); end
    checks++;
    if (fd_cnt != 0 || pe_cnt != 0) begin failures++; $display("FAIL reset_pulses: got fd=%0d pe=%0d want 0/0", fd_cnt, pe_cnt); end
    checks++;
    if (err_digit !== 2'd0) begin failures++; $display("FAIL reset_err_digit: got %0d want 0", err_digit); end
    rst_n = 1'b1;
    n = 0;
    for (int k = 1; k <= 40 && n == 0; k++) begin
      tick(4'b1110, 7'b1001111);
      if (digit_valid[0] === 1'b1) n = k;
    end
    checks++;
    if (n != S + 2) begin failures++; $display("FAIL reset_latency: got %0d clocks want %0d (0 = never)", n, S + 2); end
    checks++;
    if (digits[3:0] !== 4'h1) begin failures++; $display("FAIL reset_first_digit: got %h want 1", digits[3:0]); end
    checks++;
    if (digit_valid !== 4'b0001) begin failures++; $display("FAIL reset_first_valid: got %b want 0001", digit_valid); end
    checks++;
    if (cyc_err != 0) begin failures++; $display("FAIL reset_model: %0d cycles differ, first (got/want) %s", cyc_err, mm_note); end
  endtask

  task automatic test_full_frame();
    start_scenario();
    hold(4'b1110, 7'b0000110, 10);
    hold(4'b1101, 7'b0001000, 10);
    hold(4'b1011, 7'b0110001, 10);
    hold(4'b0111, 7'b0111000, 10);
    checks++;
    if (digits !== 16'hFCA3) begin failures++; $display("FAIL frame_digits: got %h want FCA3", digits); end
    checks++;
    if (digit_valid !== 4'b1111) begin failures++; $display("FAIL frame_valid: got %b want 1111", digit_valid); end
    checks++;
    if (fd_cnt != 1 || pe_cnt != 0) begin failures++; $display("FAIL frame_pulses: got fd=%0d pe=%0d want 1/0", fd_cnt, pe_cnt); end
    checks++;
    if (cyc_err != 0) begin failures++; $display("FAIL frame_model: %0d cycles differ, first (got/want) %s", cyc_err, mm_note); end
  endtask

  task automatic test_glitch();
    start_scenario();
    hold(4'b1110, 7'b0000110, 10);
    hold(4'b1110, 7'b0000000, S - 1);
    hold(4'b1110, 7'b0000110, 12);
    checks++;
    if (digits !== 16'hFCA3) begin failures++; $display("FAIL glitch_digits: got %h want FCA3", digits); end
    checks++;
    if (digit_valid !== 4'b1111) begin failures++; $display("FAIL glitch_valid: got %b want 1111", digit_valid); end
    checks++;
    if (fd_cnt != 0 || pe_cnt != 0) begin failures++; $display("FAIL glitch_pulses: got fd=%0d pe=%0d want 0/0", fd_cnt, pe_cnt); end
    checks++;
    if (cyc_err != 0) begin failures++; $display("FAIL glitch_model: %0d cycles differ, first (got/want) %s", cyc_err, mm_note); end
  endtask

  task automatic test_illegal();
    start_scenario();
    hold(4'b1011, 7'b1111110, 12);
    checks++;
    if (pe_cnt != 1) begin failures++; $display("FAIL illegal_err_pulses: got %0d want 1", pe_cnt); end
    checks++;
    if (err_digit !== 2'd2) begin failures++; $display("FAIL illegal_err_digit: got %0d want 2", err_digit); end
    checks++;
    if (digit_valid !== 4'b1011) begin failures++; $display("FAIL illegal_valid: got %b want 1011", digit_valid); end
    checks++;
    if (digits[11:8] !== 4'hC) begin failures++; $display("FAIL illegal_nibble_kept: got %h want C", digits[11:8]); end
    checks++;
    if (fd_cnt != 0) begin failures++; $display("FAIL illegal_no_frame: got %0d want 0", fd_cnt); end
    checks++;
    if (cyc_err != 0) begin failures++; $display("FAIL illegal_model: %0d cycles differ, first (got/want) %s", cyc_err, mm_note); end
  endtask

  task automatic test_blank_and_bad_anode();
    logic [15:0] snap_d;
    logic [3:0]  snap_v;
    start_scenario();
    hold(4'b1101, 7'b1111111, 12);
    checks++;
    if (digit_valid !== 4'b1001) begin failures++; $display("FAIL blank_valid: got %b want 1001", digit_valid); end
    checks++;
    if (pe_cnt != 0 || fd_cnt != 0) begin failures++; $display("FAIL blank_pulses: got pe=%0d fd=%0d want 0/0", pe_cnt, fd_cnt); end
    checks++;
    if (digits[7:4] !== 4'hA) begin failures++; $display("FAIL blank_nibble_kept: got %h want A", digits[7:4]); end
    snap_d = digits;
    snap_v = digit_valid;
    pe_cnt = 0;
    fd_cnt = 0;
    hold(4'b1100, 7'b0000000, 20);
    checks++;
    if (digits !== snap_d || digit_valid !== snap_v) begin
      failures++;
      $display("FAIL bad_anode_hold: got %h/%b want %h/%b", digits, digit_valid, snap_d, snap_v);
    end
    checks++;
    if (pe_cnt != 0 || fd_cnt != 0) begin failures++; $display("FAIL bad_anode_pulses: got pe=%0d fd=%0d want 0/0", pe_cnt, fd_cnt); end
    checks++;
    if (cyc_err != 0) begin failures++; $display("FAIL blank_model: %0d cycles differ, first (got/want) %s", cyc_err, mm_note); end
  endtask

  task automatic test_mid_reset();
    int n;
    start_scenario();
    hold(4'b0111, 7'b1001111, 4);
    rst_n = 1'b0;
    #1;
    checks++;
    if (digits !== 16'h0 || digit_valid !== 4'h0 || err_digit !== 2'd0) begin
      failures++;
      $display("FAIL midreset_async: got %h/%b/%0d want 0000/0000/0", digits, digit_valid, err_digit);
    end
    tick(4'b0111, 7'b1001111);
    checks++;
    if ({digits, digit_valid, frame_done, pattern_err, err_digit} !== 25'd0) begin
      failures++;
      $display("FAIL midreset_state: got %h/%b/%b/%b/%0d want all zero",
               digits, digit_valid, frame_done, pattern_err, err_digit);
    end
    rst_n = 1'b1;
    n = 0;
    for (int k = 1; k <= 40 && n == 0; k++) begin
      tick(4'b0111, 7'b1001111);
      if (digit_valid[3] === 1'b1) n = k;
    end
    checks++;
    if (n != S + 2) begin failures++; $display("FAIL midreset_latency: got %0d clocks want %0d (0 = never)", n, S + 2); end
    checks++;
    if (digits !== 16'h1000) begin failures++; $display("FAIL midreset_digits: got %h want 1000", digits); end
    checks++;
    if (cyc_err != 0) begin failures++; $display("FAIL midreset_model: %0d cycles differ, first (got/want) %s", cyc_err, mm_note); end
  endtask

  task automatic test_random();
    logic [3:0] a;
    logic [6:0] s;
    int         r;
    start_scenario();
    for (int blk = 0; blk < 120; blk++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        a = 4'b1111;
        a[$urandom_range(0, 3)] = 1'b0;
      end else if (r == 7) begin
        a = 4'b1111;
      end else begin
        a = 4'($urandom);
      end
      r = int'($urandom_range(0, 9));
      if (r < 6)       s = enc_tab[$urandom_range(0, 15)];
      else if (r == 6) s = 7'h7F;
      else             s = 7'($urandom);
      hold(a, s, int'($urandom_range(1, 12)));
    end
    checks++;
    if (digits !== m_digits || digit_valid !== m_valid) begin
      failures++;
      $display("FAIL random_final: got %h/%b want %h/%b", digits, digit_valid, m_digits, m_valid);
    end
    checks++;
    if (cyc_err != 0) begin failures++; $display("FAIL random_model: %0d cycles differ, first (got/want) %s", cyc_err, mm_note); end
  endtask

  initial begin
    enc_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0010000, 7'b0111000};
    rst_n = 1'b0;
    an    = 4'hF;
    seg   = 7'h7F;
    model_reset();
    test_reset();
    test_full_frame();
    test_glitch();
    test_illegal();
    test_blank_and_bad_anode();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
